// File: rtl/rx_stream_buffer.sv
// Domain-B capture stage: takes each receiver byte exactly once and strobes bload.
// Buffers bytes in a first-word-fall-through FIFO and checks the incrementing-counter sequence.
module rx_stream_buffer #(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          bclk,
   input  logic          brst,
   input  logic [7:0]    bdata,
   input  logic          bvalid,
   output logic          bload,
   output logic [7:0]    dout,
   output logic          dvalid,
   input  logic          dready,
   output logic [AW:0]   level,
   output logic          full,
   output logic          seq_err,
   output logic [7:0]    err_cnt,
   output logic [15:0]   word_cnt
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic {NOREF, TRACK} chk_state_e;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q, rptr_d;
   logic [AW:0]   level_q, level_d;
   logic          full_q, dvalid_q, bload_q, taken_q, taken_d;
   logic [7:0]    dout_q, dout_d, head_d;
   logic          wr_en, rd_en;

   chk_state_e    chk_state_q;
   logic [7:0]    exp_q;
   logic          seq_err_q;
   logic [7:0]    err_cnt_q;
   logic [15:0]   word_cnt_q;

   // full_q is registered, so a write is refused while full even if a read frees a slot
   assign wr_en = bvalid & ~taken_q & ~full_q;
   assign rd_en = dvalid_q & dready;

   always_comb begin
      rptr_d  = rptr_q + {{(AW-1){1'b0}}, rd_en};
      level_d = level_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      taken_d = bvalid & (taken_q | wr_en);
      // The new head may be the byte being written this very cycle
      head_d  = (wr_en && (wptr_q == rptr_d)) ? bdata : mem_q[rptr_d];
      dout_d  = (level_d != '0) ? head_d : dout_q;
   end

   always_ff @(posedge bclk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= bdata;
      end
   end

   always_ff @(posedge bclk) begin
      if (!brst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         dvalid_q <= 1'b0;
         bload_q  <= 1'b0;
         taken_q  <= 1'b0;
         dout_q   <= 8'h00;
      end else begin
         if (wr_en) begin
            wptr_q <= wptr_q + 1'b1;
         end
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         full_q   <= (level_d == FULL_LVL);
         dvalid_q <= (level_d != '0);
         bload_q  <= wr_en;
         taken_q  <= taken_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge bclk) begin
      if (!brst) begin
         chk_state_q <= NOREF;
         exp_q       <= 8'h00;
         seq_err_q   <= 1'b0;
         err_cnt_q   <= 8'h00;
         word_cnt_q  <= 16'h0000;
      end else begin
         seq_err_q <= 1'b0;
         if (wr_en) begin
            word_cnt_q <= word_cnt_q + 16'd1;
            exp_q      <= bdata + 8'd1;
            case (chk_state_q)
               NOREF: chk_state_q <= TRACK;
               TRACK: begin
                  if (bdata != exp_q) begin
                     seq_err_q <= 1'b1;
                     if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                     end
                  end
               end
               default: chk_state_q <= NOREF;
            endcase
         end
      end
   end

   assign bload    = bload_q;
   assign dout     = dout_q;
   assign dvalid   = dvalid_q;
   assign level    = level_q;
   assign full     = full_q;
   assign seq_err  = seq_err_q;
   assign err_cnt  = err_cnt_q;
   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_rx_stream_buffer.sv
// Bench for rx_stream_buffer: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_rx_stream_buffer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          bclk = 1'b0;
   logic          brst = 1'b0;
   logic [7:0]    bdata = 8'h00;
   logic          bvalid = 1'b0;
   logic          bload;
   logic [7:0]    dout;
   logic          dvalid;
   logic          dready = 1'b0;
   logic [AW:0]   level;
   logic          full;
   logic          seq_err;
   logic [7:0]    err_cnt;
   logic [15:0]   word_cnt;

   always #5 bclk = ~bclk;

   rx_stream_buffer #(.DEPTH(DEPTH)) dut (
      .bclk     (bclk),
      .brst     (brst),
      .bdata    (bdata),
      .bvalid   (bvalid),
      .bload    (bload),
      .dout     (dout),
      .dvalid   (dvalid),
      .dready   (dready),
      .level    (level),
      .full     (full),
      .seq_err  (seq_err),
      .err_cnt  (err_cnt),
      .word_cnt (word_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model: byte queue, taken flag and checker state, derived from the behaviour rules
   logic [7:0] mq[$];
   bit         m_taken   = 0;
   bit         m_has_ref = 0;
   logic [7:0] m_exp     = 8'h00;
   int         m_err     = 0;
   int         m_words   = 0;
   bit         m_bload   = 0;
   bit         m_seq_err = 0;
   bit         rand_ready = 0;

   task automatic model_update();
      bit cap;
      bit rd;
      if (!brst) begin
         mq.delete();
         m_taken = 0; m_has_ref = 0; m_exp = 8'h00;
         m_err = 0; m_words = 0; m_bload = 0; m_seq_err = 0;
      end else begin
         cap = bvalid && !m_taken && (mq.size() < DEPTH);
         rd  = (mq.size() > 0) && dready;
         if (rd) void'(mq.pop_front());
         if (cap) mq.push_back(bdata);
         m_seq_err = cap && m_has_ref && (bdata != m_exp);
         if (m_seq_err && m_err < 255) m_err++;
         if (cap) begin
            m_exp     = bdata + 8'd1;
            m_has_ref = 1;
            m_words   = (m_words + 1) % 65536;
         end
         m_taken = bvalid ? (m_taken || cap) : 1'b0;
         m_bload = cap;
      end
   endtask

   task automatic step();
      if (rand_ready) dready = ($urandom_range(0, 3) != 0);
      model_update();
      @(posedge bclk);
      #1;
      check_eq("bload",    {31'd0, bload},   {31'd0, m_bload});
      check_eq("dvalid",   {31'd0, dvalid},  (mq.size() > 0) ? 32'd1 : 32'd0);
      check_eq("level",    {28'd0, level},   mq.size());
      check_eq("full",     {31'd0, full},    (mq.size() == DEPTH) ? 32'd1 : 32'd0);
      check_eq("seq_err",  {31'd0, seq_err}, {31'd0, m_seq_err});
      check_eq("err_cnt",  {24'd0, err_cnt}, m_err);
      check_eq("word_cnt", {16'd0, word_cnt}, m_words);
      if (mq.size() > 0) check_eq("dout", {24'd0, dout}, {24'd0, mq[0]});
      if (m_bload) $display("capture 0x%02h level=%0d word_cnt=%0d", mq[$], mq.size(), m_words);
   endtask

   task automatic do_reset(input int n);
      brst   = 1'b0;
      bvalid = 1'b0;
      repeat (n) step();
      brst = 1'b1;
   endtask

   // Present a byte for at least `hold` cycles, then until captured (bounded), then drop bvalid
   task automatic send(input logic [7:0] b, input int hold);
      int dut_loads = 0;
      int k = 0;
      bit got = 0;
      bvalid = 1'b1;
      bdata  = b;
      for (int i = 0; i < hold; i++) begin
         step();
         got = got | m_bload;
         dut_loads += bload;
      end
      while (!got && k < 64) begin
         step();
         got = m_bload;
         dut_loads += bload;
         k++;
      end
      bvalid = 1'b0;
      step();
      dut_loads += bload;
      check_eq("bload_cnt", dut_loads, 1);
   endtask

   initial begin
      logic [7:0] wrap_seq [5];
      logic [7:0] brk_seq  [4];
      int         loads;
      int         r;
      wrap_seq = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
      brk_seq  = '{8'h05, 8'h06, 8'h09, 8'h0A};

      // Reset then idle, dready toggling while empty
      do_reset(3);
      for (int i = 0; i < 6; i++) begin
         dready = ~dready;
         step();
      end
      check_eq("idle_level", {28'd0, level}, 0);

      // Single word held for 5 cycles
      do_reset(1);
      dready = 1'b0;
      send(8'h10, 5);
      check_eq("single_dout", {24'd0, dout}, 8'h10);
      check_eq("single_level", {28'd0, level}, 1);
      check_eq("single_words", {16'd0, word_cnt}, 1);
      dready = 1'b1;
      step();
      check_eq("single_drain", {31'd0, dvalid}, 0);

      // Sequence wrapping through 0xFF -> 0x00
      do_reset(1);
      dready = 1'b1;
      for (int i = 0; i < 5; i++) send(wrap_seq[i], 1);
      check_eq("wrap_err", {24'd0, err_cnt}, 0);
      check_eq("wrap_words", {16'd0, word_cnt}, 5);

      // Sequence break on 0x09
      do_reset(1);
      dready = 1'b0;
      for (int i = 0; i < 4; i++) send(brk_seq[i], 1);
      check_eq("brk_err", {24'd0, err_cnt}, 1);

      // Full and backpressure
      do_reset(1);
      dready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i), 1);
      check_eq("full_flag", {31'd0, full}, 1);
      check_eq("full_level", {28'd0, level}, DEPTH);
      bvalid = 1'b1;
      bdata  = 8'h28;
      loads  = 0;
      repeat (3) begin
         step();
         loads += bload;
      end
      check_eq("full_noload", loads, 0);
      dready = 1'b1;
      step();
      dready = 1'b0;
      step();
      check_eq("full_bload9", {31'd0, bload}, 1);
      check_eq("full_relevel", {28'd0, level}, DEPTH);
      bvalid = 1'b0;
      step();
      dready = 1'b1;
      repeat (DEPTH + 2) step();
      check_eq("full_drained", {31'd0, dvalid}, 0);

      // Reset mid-stream
      do_reset(1);
      dready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1);
      brst = 1'b0;
      step();
      brst = 1'b1;
      check_eq("mid_level", {28'd0, level}, 0);
      check_eq("mid_dvalid", {31'd0, dvalid}, 0);
      check_eq("mid_words", {16'd0, word_cnt}, 0);
      send(8'h77, 1);
      check_eq("mid_err", {24'd0, err_cnt}, 0);
      check_eq("mid_words1", {16'd0, word_cnt}, 1);

      // Random traffic: in-sequence and random bytes, random backpressure, rare resets
      rand_ready = 1;
      for (int it = 0; it < 1500; it++) begin
         r = $urandom_range(0, 99);
         if (r == 0) begin
            do_reset(1);
         end else if (r < 60) begin
            if ($urandom_range(0, 1) == 0) send(m_exp, $urandom_range(1, 3));
            else send(8'($urandom_range(0, 255)), $urandom_range(1, 3));
         end else begin
            bdata = 8'($urandom_range(0, 255));
            step();
         end
      end
      rand_ready = 0;
      dready = 1'b1;
      repeat (DEPTH + 2) step();
      check_eq("final_empty", {31'd0, dvalid}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
